ramctrl: RTL and testbench

RAMCTRL -- requirements
Module: ramctrl

---
 rtl/ramctrl_if.sv | 38 +++
 rtl/ramctrl.sv | 185 ++++++++++++++++++
 tb/tb_ramctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ramctrl_if.sv
// Signal bundle linking ramctrl to its data requester, its fetch requester and the byte-wide RAM port.
interface ramctrl_if #(
  parameter int AddressWidth = 32,
  parameter int IDWidth      = 32
);
  logic                    datactrl_ramctrl_data_en_in;
  logic                    datactrl_ramctrl_data_rw_in;
  logic                    datactrl_ramctrl_data_sgn_in;
  logic [2:0]              datactrl_ramctrl_data_width_in;
  logic [AddressWidth-1:0] datactrl_ramctrl_data_addr_in;
  logic [IDWidth-1:0]      datactrl_ramctrl_data_data_in;
  logic                    ramctrl_datactrl_data_rdy_out;
  logic [IDWidth-1:0]      ramctrl_datactrl_data_data_out;
  logic                    ictrl_ramctrl_en_in;
  logic [AddressWidth-1:0] ictrl_ramctrl_addr_in;
  logic                    ramctrl_ictrl_rdy_out;
  logic [IDWidth-1:0]      ramctrl_ictrl_data_out;
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [AddressWidth-1:0] mem_a;
  logic                    mem_wr;

  modport slave (
    input  datactrl_ramctrl_data_en_in, datactrl_ramctrl_data_rw_in, datactrl_ramctrl_data_sgn_in,
    input  datactrl_ramctrl_data_width_in, datactrl_ramctrl_data_addr_in, datactrl_ramctrl_data_data_in,
    input  ictrl_ramctrl_en_in, ictrl_ramctrl_addr_in, mem_din,
    output ramctrl_datactrl_data_rdy_out, ramctrl_datactrl_data_data_out,
    output ramctrl_ictrl_rdy_out, ramctrl_ictrl_data_out, mem_dout, mem_a, mem_wr
  );

  modport master (
    output datactrl_ramctrl_data_en_in, datactrl_ramctrl_data_rw_in, datactrl_ramctrl_data_sgn_in,
    output datactrl_ramctrl_data_width_in, datactrl_ramctrl_data_addr_in, datactrl_ramctrl_data_data_in,
    output ictrl_ramctrl_en_in, ictrl_ramctrl_addr_in, mem_din,
    input  ramctrl_datactrl_data_rdy_out, ramctrl_datactrl_data_data_out,
    input  ramctrl_ictrl_rdy_out, ramctrl_ictrl_data_out, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/ramctrl.sv
// Arbitrates data load/store and instruction fetch onto a byte-wide RAM, one byte per cycle.
// state | meaning
// IDLE  | waiting; data request wins over fetch
// READ  | issuing byte addresses and collecting returned bytes
// WRITE | issuing byte writes
// DONE  | rdy pulse to the owning channel; requests ignored
module ramctrl #(
  parameter int AddressWidth = 32,
  parameter int IDWidth      = 32
) (
  input logic      clk_in,
  input logic      rst_in,
  input logic      rdy_in,
  ramctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [2:0]              len_q, len_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [IDWidth-1:0]      wdata_q, wdata_d;
  logic [IDWidth-1:0]      rbuf_q, rbuf_d;
  logic                    sgn_q, sgn_d;
  logic                    own_i_q, own_i_d;
  logic [AddressWidth-1:0] mem_a_q, mem_a_d;
  logic [7:0]              mem_dout_q, mem_dout_d;
  logic                    mem_wr_q, mem_wr_d;
  logic                    d_rdy_q, d_rdy_d, i_rdy_q, i_rdy_d;
  logic [IDWidth-1:0]      d_data_q, d_data_d, i_data_q, i_data_d;
  logic [2:0]              nxt_k;
  logic [1:0]              cap_idx;
  logic [IDWidth-1:0]      ext;

  function automatic logic [2:0] decode_len(input logic [2:0] w);
    case (w)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [IDWidth-1:0] extend(input logic [IDWidth-1:0] v, input logic [2:0] n,
                                                input logic s);
    logic [IDWidth-1:0] r;
    case (n)
      3'd1:    r = {{(IDWidth-8){s & v[7]}}, v[7:0]};
      3'd2:    r = {{(IDWidth-16){s & v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    sgn_d      = sgn_q;
    own_i_d    = own_i_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    d_rdy_d    = d_rdy_q;
    i_rdy_d    = i_rdy_q;
    d_data_d   = d_data_q;
    i_data_d   = i_data_q;
    nxt_k      = cnt_q + 3'd1;
    cap_idx    = cnt_q[1:0] - 2'd1;
    ext        = '0;
    case (state_q)
      IDLE: begin
        if (bus.datactrl_ramctrl_data_en_in) begin
          own_i_d    = 1'b0;
          addr_d     = bus.datactrl_ramctrl_data_addr_in;
          wdata_d    = bus.datactrl_ramctrl_data_data_in;
          sgn_d      = bus.datactrl_ramctrl_data_sgn_in;
          len_d      = decode_len(bus.datactrl_ramctrl_data_width_in);
          state_d    = bus.datactrl_ramctrl_data_rw_in ? WRITE : READ;
          mem_a_d    = bus.datactrl_ramctrl_data_addr_in;
          mem_wr_d   = bus.datactrl_ramctrl_data_rw_in;
          mem_dout_d = bus.datactrl_ramctrl_data_rw_in ? bus.datactrl_ramctrl_data_data_in[7:0] : 8'h00;
          cnt_d      = 3'd0;
          rbuf_d     = '0;
        end else if (bus.ictrl_ramctrl_en_in) begin
          own_i_d    = 1'b1;
          addr_d     = bus.ictrl_ramctrl_addr_in;
          sgn_d      = 1'b0;
          len_d      = 3'd4;
          state_d    = READ;
          mem_a_d    = bus.ictrl_ramctrl_addr_in;
          mem_wr_d   = 1'b0;
          mem_dout_d = 8'h00;
          cnt_d      = 3'd0;
          rbuf_d     = '0;
        end
      end
      READ: begin
        // mem_din lags mem_a by one cycle, so cycle k captures byte k-1
        if (cnt_q != 3'd0) rbuf_d[{cap_idx, 3'b000} +: 8] = bus.mem_din;
        cnt_d   = nxt_k;
        mem_a_d = (nxt_k < len_q) ? addr_q + AddressWidth'(nxt_k) : '0;
        if (cnt_q == len_q) begin
          state_d = DONE;
          cnt_d   = 3'd0;
          ext     = extend(rbuf_d, len_q, sgn_q);
          if (own_i_q) begin
            i_rdy_d  = 1'b1;
            i_data_d = ext;
          end else begin
            d_rdy_d  = 1'b1;
            d_data_d = ext;
          end
        end
      end
      WRITE: begin
        cnt_d = nxt_k;
        if (nxt_k < len_q) begin
          mem_a_d    = addr_q + AddressWidth'(nxt_k);
          mem_dout_d = wdata_q[{nxt_k[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
        end else begin
          mem_a_d    = '0;
          mem_dout_d = 8'h00;
          mem_wr_d   = 1'b0;
          state_d    = DONE;
          cnt_d      = 3'd0;
          d_rdy_d    = 1'b1;
        end
      end
      DONE: begin
        d_rdy_d = 1'b0;
        i_rdy_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      sgn_q      <= 1'b0;
      own_i_q    <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      d_rdy_q    <= 1'b0;
      i_rdy_q    <= 1'b0;
      d_data_q   <= '0;
      i_data_q   <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      sgn_q      <= sgn_d;
      own_i_q    <= own_i_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      d_rdy_q    <= d_rdy_d;
      i_rdy_q    <= i_rdy_d;
      d_data_q   <= d_data_d;
      i_data_q   <= i_data_d;
    end
  end

  // A stalled write cycle must not strobe the RAM
  assign bus.mem_wr                         = mem_wr_q & rdy_in;
  assign bus.mem_a                          = mem_a_q;
  assign bus.mem_dout                       = mem_dout_q;
  assign bus.ramctrl_datactrl_data_rdy_out  = d_rdy_q;
  assign bus.ramctrl_datactrl_data_data_out = d_data_q;
  assign bus.ramctrl_ictrl_rdy_out          = i_rdy_q;
  assign bus.ramctrl_ictrl_data_out         = i_data_q;
endmodule

// File: tb/tb_ramctrl.sv
// Self-checking bench for ramctrl: byte-RAM environment plus a byte-array reference model.
module tb_ramctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy_in = 1'b1;
  int   total = 0;
  int   bad = 0;

  ramctrl_if #(.AddressWidth(32), .IDWidth(32)) bus();
  ramctrl #(.AddressWidth(32), .IDWidth(32)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy_in), .bus(bus)
  );

  always #5 clk = ~clk;

  // RAM environment: registered read of last cycle's address, write on strobe
  logic [7:0]  ram [logic [31:0]];
  logic [7:0]  model_mem [logic [31:0]];
  logic [39:0] commits [$];
  always @(posedge clk) begin
    if (bus.mem_wr === 1'b1) begin
      ram[bus.mem_a] = bus.mem_dout;
      commits.push_back({bus.mem_a, bus.mem_dout});
    end
    bus.mem_din <= ram.exists(bus.mem_a) ? ram[bus.mem_a] : 8'h00;
  end

  int          lat, wrong_own, stall_wr, long_rdy, idle_bad;
  logic [31:0] rdata;
  logic [31:0] obs_a [16];
  logic        obs_wr [16];
  logic [7:0]  obs_do [16];

  function automatic int nbytes(input logic [2:0] w);
    return (w == 3'd1) ? 1 : (w == 3'd2) ? 2 : 4;
  endfunction

  function automatic logic [7:0] mpeek(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input bit sgn);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(mpeek(a + 32'(i))) << (8 * i);
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    model_mem[a] = b;
  endtask

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) model_mem[a + 32'(i)] = d[8*i +: 8];
  endtask

  // Issues one request at the current negedge, follows it to the owner's rdy pulse
  task automatic run_txn(input bit fetch, input bit rw, input bit sgn, input logic [2:0] w,
                         input logic [31:0] a, input logic [31:0] d, input int stall_at,
                         input int stall_len);
    lat = 0; rdata = 'x; wrong_own = 0; stall_wr = 0; long_rdy = 0; idle_bad = 0;
    commits.delete();
    if (fetch) begin
      bus.ictrl_ramctrl_en_in = 1'b1;
      bus.ictrl_ramctrl_addr_in = a;
    end else begin
      bus.datactrl_ramctrl_data_en_in = 1'b1;
      bus.datactrl_ramctrl_data_rw_in = rw;
      bus.datactrl_ramctrl_data_sgn_in = sgn;
      bus.datactrl_ramctrl_data_width_in = w;
      bus.datactrl_ramctrl_data_addr_in = a;
      bus.datactrl_ramctrl_data_data_in = d;
    end
    for (int k = 1; k < 64 && lat == 0; k++) begin
      @(negedge clk);
      if (k < 16) begin
        obs_a[k] = bus.mem_a; obs_wr[k] = bus.mem_wr; obs_do[k] = bus.mem_dout;
      end
      if (!rdy_in && bus.mem_wr !== 1'b0) stall_wr++;
      if ((fetch ? bus.ramctrl_datactrl_data_rdy_out : bus.ramctrl_ictrl_rdy_out) !== 1'b0) wrong_own++;
      if ((fetch ? bus.ramctrl_ictrl_rdy_out : bus.ramctrl_datactrl_data_rdy_out) === 1'b1) begin
        lat = k;
        rdata = fetch ? bus.ramctrl_ictrl_data_out : bus.ramctrl_datactrl_data_data_out;
      end
      if (k == stall_at) rdy_in = 1'b0;
      if (k == stall_at + stall_len) rdy_in = 1'b1;
      // latched request must ignore input churn
      if (fetch) bus.ictrl_ramctrl_addr_in = $urandom;
      else begin
        bus.datactrl_ramctrl_data_rw_in = 1'($urandom);
        bus.datactrl_ramctrl_data_sgn_in = 1'($urandom);
        bus.datactrl_ramctrl_data_width_in = 3'($urandom);
        bus.datactrl_ramctrl_data_addr_in = $urandom;
        bus.datactrl_ramctrl_data_data_in = $urandom;
      end
    end
    bus.ictrl_ramctrl_en_in = 1'b0;
    bus.datactrl_ramctrl_data_en_in = 1'b0;
    @(negedge clk);
    if ((fetch ? bus.ramctrl_ictrl_rdy_out : bus.ramctrl_datactrl_data_rdy_out) !== 1'b0) long_rdy++;
    if (bus.mem_a !== 32'h0 || bus.mem_wr !== 1'b0) idle_bad++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.mem_a !== 32'h0) begin bad++; $display("FAIL reset_mem_a: got %h want 0", bus.mem_a); end
    total++; if (bus.mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr: got %b want 0", bus.mem_wr); end
    total++; if (bus.mem_dout !== 8'h0) begin bad++; $display("FAIL reset_mem_dout: got %h want 0", bus.mem_dout); end
    total++; if (bus.ramctrl_datactrl_data_rdy_out !== 1'b0 || bus.ramctrl_ictrl_rdy_out !== 1'b0) begin
      bad++; $display("FAIL reset_rdy: got %b%b want 00", bus.ramctrl_datactrl_data_rdy_out, bus.ramctrl_ictrl_rdy_out); end
    total++; if (bus.ramctrl_datactrl_data_data_out !== 32'h0 || bus.ramctrl_ictrl_data_out !== 32'h0) begin
      bad++; $display("FAIL reset_data: got %h/%h want 0/0", bus.ramctrl_datactrl_data_data_out, bus.ramctrl_ictrl_data_out); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.mem_a !== 32'h0 || bus.mem_wr !== 1'b0) begin
      bad++; $display("FAIL idle_bus: got a=%h wr=%b want 0/0", bus.mem_a, bus.mem_wr); end
  endtask

  task automatic test_load_byte_signed;
    preload(32'h100, 8'h80);
    run_txn(1'b0, 1'b0, 1'b1, 3'd1, 32'h100, 32'h0, 0, 0);
    total++; if (lat !== 3) begin bad++; $display("FAIL lb_latency: got %0d want 3", lat); end
    total++; if (rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data: got %h want ffffff80", rdata); end
    total++; if (obs_a[1] !== 32'h100 || obs_wr[1] !== 1'b0) begin
      bad++; $display("FAIL lb_addr: got %h/%b want 100/0", obs_a[1], obs_wr[1]); end
    total++; if (long_rdy !== 0 || wrong_own !== 0) begin
      bad++; $display("FAIL lb_pulse: got long=%0d wrong=%0d want 0/0", long_rdy, wrong_own); end
  endtask

  task automatic test_store_word;
    logic [31:0] d = 32'h11223344;
    run_txn(1'b0, 1'b1, 1'b0, 3'd4, 32'h200, d, 0, 0);
    model_store(32'h200, d, 4);
    total++; if (lat !== 5) begin bad++; $display("FAIL sw_latency: got %0d want 5", lat); end
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (obs_a[k] !== 32'h200 + 32'(k - 1) || obs_wr[k] !== 1'b1 || obs_do[k] !== d[8*(k-1) +: 8]) begin
        bad++; $display("FAIL sw_byte%0d: got a=%h wr=%b d=%h want a=%h wr=1 d=%h", k, obs_a[k], obs_wr[k],
                        obs_do[k], 32'h200 + 32'(k - 1), d[8*(k-1) +: 8]);
      end
    end
    total++; if (obs_wr[5] !== 1'b0 || obs_a[5] !== 32'h0) begin
      bad++; $display("FAIL sw_rdy_cycle: got wr=%b a=%h want 0/0", obs_wr[5], obs_a[5]); end
    total++; if (commits.size() !== 4) begin bad++; $display("FAIL sw_count: got %0d want 4", commits.size()); end
    total++; if (ram[32'h203] !== 8'h11) begin bad++; $display("FAIL sw_ram: got %h want 11", ram[32'h203]); end
  endtask

  task automatic test_priority;
    int dk = 0, ik = 0;
    logic [31:0] dv = 'x, iv = 'x;
    preload(32'h400, 8'h34); preload(32'h401, 8'hF2);
    for (int i = 0; i < 4; i++) preload(32'h500 + 32'(i), 8'($urandom));
    bus.datactrl_ramctrl_data_en_in = 1'b1;
    bus.datactrl_ramctrl_data_rw_in = 1'b0;
    bus.datactrl_ramctrl_data_sgn_in = 1'b1;
    bus.datactrl_ramctrl_data_width_in = 3'd2;
    bus.datactrl_ramctrl_data_addr_in = 32'h400;
    bus.ictrl_ramctrl_en_in = 1'b1;
    bus.ictrl_ramctrl_addr_in = 32'h500;
    for (int k = 1; k < 40 && ik == 0; k++) begin
      @(negedge clk);
      if (dk == 0 && bus.ramctrl_datactrl_data_rdy_out === 1'b1) begin
        dk = k; dv = bus.ramctrl_datactrl_data_data_out; bus.datactrl_ramctrl_data_en_in = 1'b0;
      end
      if (bus.ramctrl_ictrl_rdy_out === 1'b1) begin
        ik = k; iv = bus.ramctrl_ictrl_data_out; bus.ictrl_ramctrl_en_in = 1'b0;
      end
    end
    bus.datactrl_ramctrl_data_en_in = 1'b0;
    bus.ictrl_ramctrl_en_in = 1'b0;
    @(negedge clk);
    total++; if (dk !== 4) begin bad++; $display("FAIL prio_data_lat: got %0d want 4", dk); end
    total++; if (ik !== 11) begin bad++; $display("FAIL prio_fetch_lat: got %0d want 11", ik); end
    total++; if (dv !== 32'hFFFFF234) begin bad++; $display("FAIL prio_data: got %h want fffff234", dv); end
    total++; if (iv !== ref_load(32'h500, 4, 1'b0)) begin
      bad++; $display("FAIL prio_fetch_data: got %h want %h", iv, ref_load(32'h500, 4, 1'b0)); end
    total++; if (bus.ramctrl_datactrl_data_data_out !== 32'hFFFFF234) begin
      bad++; $display("FAIL prio_data_hold: got %h want fffff234", bus.ramctrl_datactrl_data_data_out); end
  endtask

  task automatic test_wrap;
    preload(32'hFFFFFFFF, 8'hCD); preload(32'h0, 8'hAB);
    run_txn(1'b0, 1'b0, 1'b0, 3'd2, 32'hFFFFFFFF, 32'h0, 0, 0);
    total++; if (lat !== 4) begin bad++; $display("FAIL wrap_latency: got %0d want 4", lat); end
    total++; if (rdata !== 32'h0000ABCD) begin bad++; $display("FAIL wrap_data: got %h want 0000abcd", rdata); end
    total++; if (obs_a[1] !== 32'hFFFFFFFF || obs_a[2] !== 32'h0) begin
      bad++; $display("FAIL wrap_addr: got %h,%h want ffffffff,00000000", obs_a[1], obs_a[2]); end
  endtask

  task automatic test_stall;
    logic [31:0] d = $urandom;
    run_txn(1'b0, 1'b1, 1'b0, 3'd4, 32'h600, d, 2, 3);
    model_store(32'h600, d, 4);
    total++; if (lat !== 8) begin bad++; $display("FAIL stall_latency: got %0d want 8", lat); end
    total++; if (stall_wr !== 0) begin bad++; $display("FAIL stall_wr: got %0d strobes want 0", stall_wr); end
    total++; if (commits.size() !== 4) begin bad++; $display("FAIL stall_count: got %0d want 4", commits.size()); end
    for (int i = 0; i < 4 && i < commits.size(); i++) begin
      total++;
      if (commits[i] !== {32'h600 + 32'(i), d[8*i +: 8]}) begin
        bad++; $display("FAIL stall_byte%0d: got %h want %h", i, commits[i], {32'h600 + 32'(i), d[8*i +: 8]});
      end
    end
  endtask

  task automatic test_reset_abort;
    int csz;
    for (int i = 0; i < 4; i++) preload(32'h700 + 32'(i), 8'h00);
    commits.delete();
    bus.datactrl_ramctrl_data_en_in = 1'b1;
    bus.datactrl_ramctrl_data_rw_in = 1'b1;
    bus.datactrl_ramctrl_data_sgn_in = 1'b0;
    bus.datactrl_ramctrl_data_width_in = 3'd4;
    bus.datactrl_ramctrl_data_addr_in = 32'h700;
    bus.datactrl_ramctrl_data_data_in = 32'hA5A5A5A5;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    csz = commits.size();
    total++; if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h0) begin
      bad++; $display("FAIL abort_bus: got wr=%b a=%h want 0/0", bus.mem_wr, bus.mem_a); end
    total++; if (bus.ramctrl_datactrl_data_rdy_out !== 1'b0 || bus.ramctrl_datactrl_data_data_out !== 32'h0) begin
      bad++; $display("FAIL abort_rdy: got rdy=%b d=%h want 0/0", bus.ramctrl_datactrl_data_rdy_out,
                      bus.ramctrl_datactrl_data_data_out); end
    total++; if (csz !== 2) begin bad++; $display("FAIL abort_writes: got %0d want 2", csz); end
    model_store(32'h700, 32'hA5A5A5A5, 2);
    rst = 1'b0;
    run_txn(1'b0, 1'b0, 1'b0, 3'd1, 32'h702, 32'h0, 0, 0);
    total++; if (lat !== 3) begin bad++; $display("FAIL abort_reaccept: got %0d want 3", lat); end
    total++; if (rdata !== 32'h0 || commits.size() !== 0) begin
      bad++; $display("FAIL abort_no_write: got d=%h writes=%0d want 0/0", rdata, commits.size()); end
  endtask

  task automatic test_illegal_width;
    for (int i = 0; i < 4; i++) preload(32'h800 + 32'(i), 8'($urandom));
    run_txn(1'b0, 1'b0, 1'b1, 3'd3, 32'h800, 32'h0, 0, 0);
    total++; if (lat !== 6) begin bad++; $display("FAIL illw_latency: got %0d want 6", lat); end
    total++; if (rdata !== ref_load(32'h800, 4, 1'b1)) begin
      bad++; $display("FAIL illw_data: got %h want %h", rdata, ref_load(32'h800, 4, 1'b1)); end
  endtask

  task automatic test_random;
    bit f, rw, sgn;
    logic [2:0] w;
    logic [31:0] a, d, exp;
    int n;
    for (int i = 0; i < 64; i++) preload(32'h1000 + 32'(i), 8'($urandom));
    for (int i = 0; i < 4; i++) preload(32'hFFFFFFFC + 32'(i), 8'($urandom));
    for (int t = 0; t < 40; t++) begin
      f = ($urandom_range(0, 4) == 0);
      rw = f ? 1'b0 : 1'($urandom);
      sgn = 1'($urandom);
      w = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                      : 32'h1000 + 32'($urandom_range(0, 63));
      d = $urandom;
      n = f ? 4 : nbytes(w);
      exp = ref_load(a, n, f ? 1'b0 : sgn);
      run_txn(f, rw, sgn, w, a, d, 0, 0);
      total++; if (lat !== (rw ? n + 1 : n + 2)) begin
        bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, lat, rw ? n + 1 : n + 2); end
      if (!rw) begin
        total++; if (rdata !== exp) begin bad++; $display("FAIL rnd%0d_data: got %h want %h", t, rdata, exp); end
      end else begin
        total++; if (commits.size() !== n) begin
          bad++; $display("FAIL rnd%0d_writes: got %0d want %0d", t, commits.size(), n); end
        for (int i = 0; i < n && i < commits.size(); i++) begin
          total++;
          if (commits[i] !== {a + 32'(i), d[8*i +: 8]}) begin
            bad++; $display("FAIL rnd%0d_byte%0d: got %h want %h", t, i, commits[i], {a + 32'(i), d[8*i +: 8]});
          end
        end
        model_store(a, d, n);
      end
      total++; if (wrong_own !== 0 || long_rdy !== 0 || idle_bad !== 0) begin
        bad++; $display("FAIL rnd%0d_proto: got wrong=%0d long=%0d idle=%0d want 0/0/0", t, wrong_own, long_rdy,
                        idle_bad); end
    end
  endtask

  initial begin
    bus.datactrl_ramctrl_data_en_in = 1'b0;
    bus.datactrl_ramctrl_data_rw_in = 1'b0;
    bus.datactrl_ramctrl_data_sgn_in = 1'b0;
    bus.datactrl_ramctrl_data_width_in = 3'd0;
    bus.datactrl_ramctrl_data_addr_in = 32'h0;
    bus.datactrl_ramctrl_data_data_in = 32'h0;
    bus.ictrl_ramctrl_en_in = 1'b0;
    bus.ictrl_ramctrl_addr_in = 32'h0;
    test_reset();
    test_load_byte_signed();
    test_store_word();
    test_priority();
    test_wrap();
    test_stall();
    test_reset_abort();
    test_illegal_width();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
